// File: rtl/serial_add_pkg.sv
// Shared definitions for the digit-serial adder: FSM state encoding,
// digit width and the default operand length in digits.
package serial_add_pkg;

  localparam int DIGIT_W     = 4;
  localparam int NIBBLES_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_adder.sv
// One-digit ripple adder built from explicit full-adder gate equations.
// Purely combinational; the controller time-multiplexes a single instance.
module nibble_adder
  import serial_add_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               cin,
  output logic [DIGIT_W-1:0] sum,
  output logic               cout
);

  logic [DIGIT_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < DIGIT_W; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[DIGIT_W];

endmodule

// File: rtl/serial_add_ctrl.sv
// Digit-serial W-bit adder: accepts one operand pair, adds one 4-bit digit
// per cycle through a shared nibble_adder, then holds the result until the
// consumer takes it (valid/ready on both sides).
// Optional build macro SERIAL_ADD_SUB_EN adds an in_sub input that turns the
// operation into A - B (B digits inverted, initial carry forced to 1).
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter  int NIBBLES = NIBBLES_DEF,
  localparam int W       = DIGIT_W * NIBBLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic         in_sub,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_cout,
  output logic         busy
);

  localparam int CNT_W = $clog2(NIBBLES);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               carry_q;
  logic [W-1:0]       a_q;
  logic [W-1:0]       b_q;
  logic [W-1:0]       sum_q;
  logic               cout_q;
  logic               out_valid_q;
  logic               in_ready_q;
  logic               busy_q;

  logic               accept;
  logic               cin_init;
  logic               last_digit;
  logic [CNT_W+1:0]   bit_idx;
  logic [DIGIT_W-1:0] dig_a;
  logic [DIGIT_W-1:0] dig_b;
  logic [DIGIT_W-1:0] dig_sum;
  logic               dig_cout;

`ifdef SERIAL_ADD_SUB_EN
  logic sub_q;
  assign cin_init = in_sub ? 1'b1 : in_cin;
  assign dig_b    = b_q[bit_idx +: DIGIT_W] ^ {DIGIT_W{sub_q}};
`else
  assign cin_init = in_cin;
  assign dig_b    = b_q[bit_idx +: DIGIT_W];
`endif

  assign accept     = (state == ST_IDLE) && in_valid;
  assign last_digit = (cnt == CNT_W'(NIBBLES - 1));
  // Digit width is 4, so the bit offset of digit cnt is cnt with two zero LSBs.
  assign bit_idx    = {cnt, 2'b00};
  assign dig_a      = a_q[bit_idx +: DIGIT_W];

  nibble_adder u_nibble_adder (
    .a    (dig_a),
    .b    (dig_b),
    .cin  (carry_q),
    .sum  (dig_sum),
    .cout (dig_cout)
  );

  // Operand capture on acceptance; later changes on the inputs are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q   <= in_a;
      b_q   <= in_b;
`ifdef SERIAL_ADD_SUB_EN
      sub_q <= in_sub;
`endif
    end
  end

  // Control FSM with registered handshake outputs and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      carry_q     <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            state      <= ST_RUN;
            cnt        <= '0;
            carry_q    <= cin_init;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        ST_RUN: begin
          sum_q[bit_idx +: DIGIT_W] <= dig_sum;
          carry_q                   <= dig_cout;
          if (last_digit) begin
            state       <= ST_DONE;
            cout_q      <= dig_cout;
            out_valid_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state       <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // in_ready is forced low for as long as reset is held.
  assign in_ready  = in_ready_q & rst_n;
  assign out_valid = out_valid_q;
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign busy      = busy_q;

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter NIBBLES, default 4: number of 4-bit digits per operand; W = 4*NIBBLES; legal range 2..16.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  operand request valid.
REQ-005 in_ready  output  1  block can accept an operand request.
REQ-006 in_a  input  W  operand A.
REQ-007 in_b  input  W  operand B.
REQ-008 in_cin  input  1  carry-in for bit 0.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 out_sum  output  W  result sum.
REQ-012 out_cout  output  1  carry out of bit W-1.
REQ-013 busy  output  1  high in RUN or DONE.

Function
REQ-014 Three-state FSM: IDLE, RUN, DONE; encoding comes from the shared package.
REQ-015 IDLE: in_ready=1; when in_valid=1, latch in_a, in_b and in_cin (carry register), clear the digit counter and go to RUN.
REQ-016 RUN: each cycle, one 4-bit adder instance adds digit[cnt] of A, digit[cnt] of B and the carry register; the sum is written to out_sum digit cnt, the carry register takes the adder cout, and cnt increments.
REQ-017 RUN -> DONE on the edge that processes digit NIBBLES-1; out_cout = final carry.
REQ-018 Latency: out_valid rises exactly NIBBLES cycles after the accepting edge.
REQ-019 DONE: out_valid=1; out_sum and out_cout are held stable until the out_valid&&out_ready edge, then the FSM goes to IDLE.
REQ-020 in_ready=0 in RUN and DONE; a request is never accepted in the same cycle a result is consumed. Minimum issue interval is NIBBLES+2 cycles.
REQ-021 in_valid and operands are ignored outside IDLE; operand changes after acceptance do not affect the result.
REQ-022 out_ready is ignored outside DONE.
REQ-023 Result equals (A + B + cin) mod 2^W, and out_cout equals bit W of the full sum.
REQ-024 cnt width is clog2(NIBBLES); cnt does not wrap within a transaction.

Reset
REQ-025 rst_n=0 at a rising edge forces IDLE, cnt=0, carry register 0, out_sum=0, out_cout=0, out_valid=0, in_ready=1 (after release), busy=0.
REQ-026 Reset during RUN or DONE abandons the transaction; no partial result becomes visible.
REQ-027 While rst_n=0, in_ready is driven 0.

Configuration
REQ-028 Macro SERIAL_ADD_SUB_EN defined: an extra input in_sub (1 bit) is latched with the operands. When in_sub=1, each B digit is inverted before the adder and the initial carry is forced to 1 (in_cin ignored), giving A-B mod 2^W; out_cout=1 means no borrow.
REQ-029 Macro undefined: port in_sub is absent and the block is add-only, per REQ-023.

Structure
REQ-030 Shared package serial_add_pkg holds the FSM state typedef (IDLE/RUN/DONE), the DIGIT_W=4 constant and the default NIBBLES.
REQ-031 Single sub-module nibble_adder (4-bit a, b, cin -> 4-bit sum, cout, purely combinational, gate-level full-adder cascade) is instantiated once.
REQ-032 No other arithmetic on the datapath is permitted besides nibble_adder and the cnt increment.

Verification
REQ-033 NIBBLES=4: A=0x1234, B=0x4321, cin=0 -> out_sum=0x5555, out_cout=0, out_valid 4 cycles after acceptance.
REQ-034 A=0xFFFF, B=0x0001, cin=0 -> 0x0000, cout=1 (carry ripples across all digits); A=0xFFFF, B=0xFFFF, cin=1 -> 0xFFFF, cout=1.
REQ-035 Backpressure: out_ready held 0 for 5 cycles in DONE -> out_sum stable and in_ready=0 throughout; a new in_valid presented meanwhile is accepted only after the consume edge plus one cycle.
REQ-036 Reset asserted on the 2nd RUN cycle -> next cycle IDLE, out_valid=0, out_sum=0; the following request 0x0001+0x0001 -> 0x0002.
REQ-037 SERIAL_ADD_SUB_EN defined: 0x0005 minus 0x0007 -> 0xFFFE, cout=0; 0x0007 minus 0x0005 -> 0x0002, cout=1.
